pps_discipline_ctrl: RTL and testbench
======================================

Name: pps_discipline_ctrl

Overview:
- Sequences the fabric 1PPS timebase from the 1PPS timestamp block outputs (sync_1pps, sta_pps_locked).
- Runs a local phase counter and disciplines it to the external pulse when qualified. Bridges short outages in holdover and falls back to free-run otherwise.
- Produces the system pps tick, a seconds counter with a deferred load, and status for the register bank.

Parameters:
C_CLOCK_FREQUENCY, 125000000, clk_125m cycles per second (F)
C_TOL, 8, max |phase error| in cycles accepted for realign
C_LOCK_SEC, 4, consecutive qualified pulses needed before alignment
C_HOLDOVER_SEC, 16, ticks allowed in HOLDOVER before FREERUN

Ports:
clk_125m  in  1  system clock
rst_125m  in  1  reset; asynchronous, active-high
sync_1pps  in  1  one-cycle pulse from the 1PPS timestamp block
pps_locked  in  1  lock status from the 1PPS timestamp block
ctrl_enable  in  1  1 = discipline allowed; 0 = forced FREERUN
sec_load_valid  in  1  one-cycle strobe, load seconds value
sec_load_value  in  32  seconds value to apply
pps_out  out  1  one-cycle system tick
sec_cnt  out  32  seconds count
sub_cnt  out  $clog2(F)  phase counter (ph_cnt)
state  out  2  00 FREERUN, 01 ALIGN, 10 LOCKED, 11 HOLDOVER
phase_err  out  8  signed error of last accepted or rejected pulse, saturated to ±127
sta_disciplined  out  1  state == LOCKED

Behaviour:
Reset and counter
- Async reset clears everything to 0 immediately, state = FREERUN, pending load cleared. This applies mid-operation as well.
- ph_cnt_next = 0 if realign, else (ph_cnt == F-1 ? 0 : ph_cnt+1).

Phase error and tick
- Phase error e on sync_1pps: ph_cnt >= F/2 → e = ph_cnt-(F-1) (≤0, early); else e = ph_cnt+1 (late). In-tolerance: |e| <= C_TOL.
- Tick when ph_cnt_next == 0, except a realign with ph_cnt < F/2 gives no tick (that second was already counted).
- Tick is registered: pps_out high the cycle after the tick decision, for exactly one cycle. sec_cnt updates in the same cycle pps_out rises.
- sec_cnt update on tick: pending load ? sec_load_value_latched : sec_cnt+1. Wraps modulo 2^32.
- sec_load_valid at cycle t is latched as pending and takes effect at the first tick decided strictly after t. A newer load overwrites the pending value.

Qualification and watchdog
- qualified pulse = sync_1pps && pps_locked && ctrl_enable.
- good_cnt: increments on each qualified pulse, saturating at C_LOCK_SEC. Clears on pps_locked low or when leaving ALIGN/LOCKED to FREERUN.
- miss_cnt: cycles since the last sync_1pps, saturating. Cleared by sync_1pps.
- phase_err updates on every sync_1pps in ALIGN, LOCKED and HOLDOVER.

States
- FREERUN: ph_cnt free-runs, no realign.
  - good_cnt reaches C_LOCK_SEC → ALIGN.
- ALIGN: the next qualified pulse realigns unconditionally (any e) → LOCKED.
  - pps_locked low → FREERUN.
- LOCKED:
  - qualified in-tolerance pulse → realign.
  - out-of-tolerance pulse → FREERUN, no realign.
  - pps_locked low, or miss_cnt > F+C_TOL → HOLDOVER, ho_cnt = 0.
- HOLDOVER: free-run; ho_cnt increments per tick.
  - qualified in-tolerance pulse → realign → LOCKED.
  - out-of-tolerance qualified pulse → FREERUN.
  - ho_cnt == C_HOLDOVER_SEC → FREERUN.
- ctrl_enable low → FREERUN from any state. This has the highest priority.
- A transition and a tick in the same cycle are both honoured. Tick generation is never suppressed by a state change except by the late-realign rule.

Test Plan:
Bench parameters for all scenarios: F=1000, C_TOL=4, C_LOCK_SEC=4, C_HOLDOVER_SEC=3.
1. Reset, ctrl_enable=1, no pulses → state 00; pps_out every 1000 cycles; sec_cnt 1,2,3…; async reset mid-second clears sub_cnt/sec_cnt the same cycle.
2. pps_locked=1, sync_1pps every 1000 cycles at ph_cnt=300 → ALIGN after 4th pulse; 5th realigns with e=301 and no tick → LOCKED; later pulses e=0; tick interval 1000.
3. LOCKED, one pulse arrives 3 cycles early → realign, e=-3, tick emitted, no double count; pulse 6 cycles late → state 00, phase_err=+6.
4. LOCKED, pulses stop → HOLDOVER at miss_cnt=1005; 3 ticks later → FREERUN. Variant: pulse resumes with e=+2 after 2 ticks → LOCKED.
5. sec_load_valid with 0x12345678 at ph_cnt=500 → next pps_out shows sec_cnt=0x12345678, following tick 0x12345679. Load in the tick-decision cycle → applied one tick later.
6. ctrl_enable dropped in LOCKED → FREERUN next cycle; good_cnt cleared; relock needs 4 fresh pulses.

Source files
------------

// File: rtl/pps_discipline_ctrl.sv
// 1PPS discipline controller: local phase counter steered by the external
// pulse, with holdover/free-run fallback, seconds counter and status.
module pps_discipline_ctrl #(
    parameter int C_CLOCK_FREQUENCY = 125000000,
    parameter int C_TOL             = 8,
    parameter int C_LOCK_SEC        = 4,
    parameter int C_HOLDOVER_SEC    = 16
) (
    input  logic                                 clk_125m,
    input  logic                                 rst_125m,
    input  logic                                 sync_1pps,
    input  logic                                 pps_locked,
    input  logic                                 ctrl_enable,
    input  logic                                 sec_load_valid,
    input  logic [31:0]                          sec_load_value,
    output logic                                 pps_out,
    output logic [31:0]                          sec_cnt,
    output logic [$clog2(C_CLOCK_FREQUENCY)-1:0] sub_cnt,
    output logic [1:0]                           state,
    output logic [7:0]                           phase_err,
    output logic                                 sta_disciplined
);

    localparam int PW = $clog2(C_CLOCK_FREQUENCY);
    localparam int EW = PW + 2;
    localparam int MW = $clog2(C_CLOCK_FREQUENCY + C_TOL + 2);
    localparam int GW = $clog2(C_LOCK_SEC + 1);
    localparam int HW = $clog2(C_HOLDOVER_SEC + 1);

    localparam logic [PW-1:0] PH_MAX   = PW'(C_CLOCK_FREQUENCY - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(C_CLOCK_FREQUENCY / 2);
    localparam logic [MW-1:0] MISS_MAX = MW'(C_CLOCK_FREQUENCY + C_TOL + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(C_LOCK_SEC);
    localparam logic [HW-1:0] HO_MAX   = HW'(C_HOLDOVER_SEC);

    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_TOL  = EW'(C_TOL);
    localparam logic signed [EW-1:0] E_SATP = EW'(127);
    localparam logic signed [EW-1:0] E_SATN = EW'(-127);

    typedef enum logic [1:0] {
        ST_FREERUN  = 2'b00,
        ST_ALIGN    = 2'b01,
        ST_LOCKED   = 2'b10,
        ST_HOLDOVER = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ph_cnt_q, ph_cnt_d;
    logic [31:0]    sec_cnt_q, sec_cnt_d;
    logic           pps_q, pps_d;
    logic [7:0]     phase_err_q, phase_err_d;
    logic [GW-1:0]  good_cnt_q, good_cnt_d;
    logic [MW-1:0]  miss_cnt_q, miss_cnt_d;
    logic [HW-1:0]  ho_cnt_q, ho_cnt_d;
    logic           load_pend_q, load_pend_d;
    logic [31:0]    load_val_q, load_val_d;

    logic signed [EW-1:0] err;
    logic signed [EW-1:0] err_abs;
    logic [7:0]           err_sat;
    logic                 in_tol;
    logic                 qual;
    logic                 realign;
    logic                 tick;

    assign qual = sync_1pps && pps_locked && ctrl_enable;

    // Upper half of the second means the pulse came early (e <= 0).
    always_comb begin
        if (ph_cnt_q >= PH_HALF) begin
            err = $signed({2'b00, ph_cnt_q}) - $signed({2'b00, PH_MAX});
        end else begin
            err = $signed({2'b00, ph_cnt_q}) + E_ONE;
        end
        err_abs = err[EW-1] ? -err : err;
        in_tol  = (err_abs <= E_TOL);
        if (err > E_SATP) begin
            err_sat = 8'sd127;
        end else if (err < E_SATN) begin
            err_sat = -8'sd127;
        end else begin
            err_sat = err[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        realign = 1'b0;
        if (!ctrl_enable) begin
            state_d = ST_FREERUN;
        end else begin
            unique case (state_q)
                ST_FREERUN: begin
                    if (pps_locked && good_cnt_q == GOOD_MAX) begin
                        state_d = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (!pps_locked) begin
                        state_d = ST_FREERUN;
                    end else if (qual) begin
                        realign = 1'b1;
                        state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!pps_locked) begin
                        state_d = ST_HOLDOVER;
                    end else if (qual) begin
                        if (in_tol) begin
                            realign = 1'b1;
                        end else begin
                            state_d = ST_FREERUN;
                        end
                    end else if (miss_cnt_q == MISS_MAX) begin
                        state_d = ST_HOLDOVER;
                    end
                end
                ST_HOLDOVER: begin
                    if (ho_cnt_q == HO_MAX) begin
                        state_d = ST_FREERUN;
                    end else if (qual) begin
                        if (in_tol) begin
                            realign = 1'b1;
                            state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_FREERUN;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        if (realign || ph_cnt_q == PH_MAX) begin
            ph_cnt_d = '0;
        end else begin
            ph_cnt_d = ph_cnt_q + 1'b1;
        end

        // A late realign lands in a second that has already been ticked.
        tick  = (ph_cnt_d == '0) && !(realign && ph_cnt_q < PH_HALF);
        pps_d = tick;

        sec_cnt_d   = sec_cnt_q;
        load_pend_d = load_pend_q;
        load_val_d  = load_val_q;
        if (tick) begin
            sec_cnt_d   = load_pend_q ? load_val_q : sec_cnt_q + 1'b1;
            load_pend_d = 1'b0;
        end
        if (sec_load_valid) begin
            load_pend_d = 1'b1;
            load_val_d  = sec_load_value;
        end

        good_cnt_d = good_cnt_q;
        if (!pps_locked || (state_d == ST_FREERUN && state_q != ST_FREERUN)) begin
            good_cnt_d = '0;
        end else if (qual && good_cnt_q != GOOD_MAX) begin
            good_cnt_d = good_cnt_q + 1'b1;
        end

        miss_cnt_d = miss_cnt_q;
        if (sync_1pps) begin
            miss_cnt_d = '0;
        end else if (miss_cnt_q != MISS_MAX) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end

        ho_cnt_d = ho_cnt_q;
        if (state_q != ST_HOLDOVER) begin
            ho_cnt_d = '0;
        end else if (tick && ho_cnt_q != HO_MAX) begin
            ho_cnt_d = ho_cnt_q + 1'b1;
        end

        phase_err_d = phase_err_q;
        if (sync_1pps && state_q != ST_FREERUN) begin
            phase_err_d = err_sat;
        end
    end

    always_ff @(posedge clk_125m or posedge rst_125m) begin
        if (rst_125m) begin
            state_q     <= ST_FREERUN;
            ph_cnt_q    <= '0;
            sec_cnt_q   <= '0;
            pps_q       <= 1'b0;
            phase_err_q <= '0;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            ho_cnt_q    <= '0;
            load_pend_q <= 1'b0;
            load_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            ph_cnt_q    <= ph_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            pps_q       <= pps_d;
            phase_err_q <= phase_err_d;
            good_cnt_q  <= good_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            ho_cnt_q    <= ho_cnt_d;
            load_pend_q <= load_pend_d;
            load_val_q  <= load_val_d;
        end
    end

    assign pps_out         = pps_q;
    assign sec_cnt         = sec_cnt_q;
    assign sub_cnt         = ph_cnt_q;
    assign state           = state_q;
    assign phase_err       = phase_err_q;
    assign sta_disciplined = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_pps_discipline_ctrl.sv
// Bench for pps_discipline_ctrl: expected ticks queued by the stimulus,
// popped and compared by a monitor whenever pps_out is seen.
module tb_pps_discipline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic        locked = 1'b0;
    logic        en = 1'b1;
    logic        ld_v = 1'b0;
    logic [31:0] ld_val = 32'd0;
    logic        pps;
    logic [31:0] sec;
    logic [9:0]  sub;
    logic [1:0]  st;
    logic [7:0]  perr;
    logic        disc;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int base = 0;
    int a = 0;
    int a2 = 0;

    typedef struct {
        int          c;
        logic [31:0] s;
    } tick_t;

    tick_t q[$];
    tick_t t;

    pps_discipline_ctrl #(
        .C_CLOCK_FREQUENCY(1000),
        .C_TOL(4),
        .C_LOCK_SEC(4),
        .C_HOLDOVER_SEC(3)
    ) dut (
        .clk_125m(clk),
        .rst_125m(rst),
        .sync_1pps(sync),
        .pps_locked(locked),
        .ctrl_enable(en),
        .sec_load_valid(ld_v),
        .sec_load_value(ld_val),
        .pps_out(pps),
        .sec_cnt(sec),
        .sub_cnt(sub),
        .state(st),
        .phase_err(perr),
        .sta_disciplined(disc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && pps) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL tick: unexpected at cyc %0d sec=%h", cyc, sec);
            end else begin
                t = q.pop_front();
                if (t.c != cyc || t.s !== sec) begin
                    bad++;
                    $display("FAIL tick: got cyc %0d sec %h, want cyc %0d sec %h",
                             cyc, sec, t.c, t.s);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic exp_tick(input int c, input logic [31:0] s);
        tick_t e;
        e.c = c;
        e.s = s;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        if (cyc > c) begin
            total++;
            bad++;
            $display("FAIL schedule: at cyc %0d already past %0d", cyc, c);
        end
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input int c);
        wait_cyc(c);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic load(input int c, input logic [31:0] v);
        wait_cyc(c);
        ld_v = 1'b1;
        ld_val = v;
        @(negedge clk);
        ld_v = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sync = 1'b0;
        ld_v = 1'b0;
        en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = cyc;
    endtask

    // Five on-time pulses at phase 999: ALIGN after the 4th, LOCKED after the 5th.
    task automatic lock_up();
        for (int j = 0; j < 5; j++) pulse(base + 999 + 1000 * j);
    endtask

    task automatic drained(input string nm);
        chk(nm, 32'(q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst sub", 32'(sub), 32'd0);
        chk("rst sec", sec, 32'd0);
        chk("rst state", 32'(st), 32'd0);
        chk("rst pps", 32'(pps), 32'd0);
        chk("rst perr", 32'(perr), 32'd0);
        chk("rst disc", 32'(disc), 32'd0);
        rst = 1'b0;
        base = cyc;

        // free-run ticks, then async reset mid-second
        for (int k = 1; k <= 3; k++) exp_tick(base + 1000 * k, 32'(k));
        wait_cyc(base + 1500);
        chk("s1 state", 32'(st), 32'd0);
        wait_cyc(base + 3500);
        chk("s1 sub mid", 32'(sub), 32'd500);
        chk("s1 sec", sec, 32'd3);
        drained("s1 drained");
        #2 rst = 1'b1;
        #1;
        chk("s1 async sub", 32'(sub), 32'd0);
        chk("s1 async sec", sec, 32'd0);

        // qualification at phase 300 and late alignment
        do_reset();
        locked = 1'b1;
        for (int k = 1; k <= 4; k++) exp_tick(base + 1000 * k, 32'(k));
        for (int j = 0; j < 4; j++) pulse(base + 300 + 1000 * j);
        wait_cyc(base + 3310);
        chk("s2 align", 32'(st), 32'd1);
        chk("s2 perr freerun", 32'(perr), 32'd0);
        a = base + 4301;
        exp_tick(a + 1000, 32'd5);
        exp_tick(a + 2000, 32'd6);
        pulse(base + 4300);
        wait_cyc(a);
        chk("s2 locked", 32'(st), 32'd2);
        chk("s2 perr sat", 32'(perr), 32'd127);
        chk("s2 sub realign", 32'(sub), 32'd0);
        chk("s2 disc", 32'(disc), 32'd1);
        pulse(a + 999);
        wait_cyc(a + 1000);
        chk("s2 perr zero", 32'(perr), 32'd0);
        pulse(a + 1999);

        // early pulse realigns with tick, late pulse drops lock
        a2 = a + 2997;
        exp_tick(a2, 32'd7);
        exp_tick(a2 + 1000, 32'd8);
        exp_tick(a2 + 2000, 32'd9);
        pulse(a + 2996);
        wait_cyc(a2);
        chk("s3 perr early", 32'(perr), 32'h0000_00FD);
        chk("s3 state early", 32'(st), 32'd2);
        chk("s3 sub early", 32'(sub), 32'd0);
        pulse(a2 + 999);
        pulse(a2 + 1005);
        wait_cyc(a2 + 1006);
        chk("s3 state late", 32'(st), 32'd0);
        chk("s3 perr late", 32'(perr), 32'd6);
        chk("s3 disc late", 32'(disc), 32'd0);
        wait_cyc(a2 + 2010);
        drained("s3 drained");

        // holdover expiry
        do_reset();
        locked = 1'b1;
        for (int k = 1; k <= 9; k++) exp_tick(base + 1000 * k, 32'(k));
        lock_up();
        wait_cyc(base + 5000);
        chk("s4 locked", 32'(st), 32'd2);
        wait_cyc(base + 6005);
        chk("s4 pre holdover", 32'(st), 32'd2);
        wait_cyc(base + 6006);
        chk("s4 holdover", 32'(st), 32'd3);
        wait_cyc(base + 9000);
        chk("s4 ho last", 32'(st), 32'd3);
        wait_cyc(base + 9001);
        chk("s4 ho expire", 32'(st), 32'd0);
        wait_cyc(base + 9010);
        drained("s4 drained");

        // holdover recovery with a slightly late pulse
        do_reset();
        locked = 1'b1;
        for (int k = 1; k <= 8; k++) exp_tick(base + 1000 * k, 32'(k));
        exp_tick(base + 9002, 32'd9);
        lock_up();
        wait_cyc(base + 8000);
        chk("s4b holdover", 32'(st), 32'd3);
        pulse(base + 8001);
        chk("s4b relock", 32'(st), 32'd2);
        chk("s4b perr", 32'(perr), 32'd2);
        chk("s4b sub", 32'(sub), 32'd0);
        wait_cyc(base + 9012);
        drained("s4b drained");

        // deferred seconds load
        do_reset();
        locked = 1'b0;
        exp_tick(base + 1000, 32'h1234_5678);
        exp_tick(base + 2000, 32'h1234_5679);
        exp_tick(base + 3000, 32'h1234_567A);
        exp_tick(base + 4000, 32'hA000_0000);
        exp_tick(base + 5000, 32'h0000_0022);
        exp_tick(base + 6000, 32'h0000_0023);
        exp_tick(base + 7000, 32'hFFFF_FFFF);
        exp_tick(base + 8000, 32'h0000_0000);
        load(base + 500, 32'h1234_5678);
        load(base + 2999, 32'hA000_0000);
        load(base + 4200, 32'h0000_0011);
        load(base + 4600, 32'h0000_0022);
        load(base + 6500, 32'hFFFF_FFFF);
        wait_cyc(base + 8010);
        drained("s5 drained");
        chk("s5 sec wrap", sec, 32'd0);

        // ctrl_enable drop and fresh relock
        do_reset();
        locked = 1'b1;
        for (int k = 1; k <= 10; k++) exp_tick(base + 1000 * k, 32'(k));
        lock_up();
        wait_cyc(base + 5500);
        chk("s6 locked", 32'(st), 32'd2);
        en = 1'b0;
        wait_cyc(base + 5501);
        chk("s6 forced freerun", 32'(st), 32'd0);
        chk("s6 disc", 32'(disc), 32'd0);
        wait_cyc(base + 5600);
        en = 1'b1;
        pulse(base + 5999);
        pulse(base + 6999);
        pulse(base + 7999);
        pulse(base + 8999);
        chk("s6 still freerun", 32'(st), 32'd0);
        wait_cyc(base + 9001);
        chk("s6 realign state", 32'(st), 32'd1);
        pulse(base + 9999);
        chk("s6 relocked", 32'(st), 32'd2);
        wait_cyc(base + 10010);
        drained("s6 drained");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
